trap_ctrl: RTL and testbench
============================

# trap_ctrl

Machine-mode trap controller. It is the consumer of the exception vector produced by instruction decode and owns the M-mode trap CSRs.
- Accepts one committed ECALL/EBREAK/MRET at a time through a valid/ready handshake.
- Updates mstatus/mepc/mcause, then issues a one-cycle pipeline flush with the redirect PC.
- Sits between the commit point of the NPC pipeline and the fetch PC mux, and also serves the EX-stage Zicsr read/write port.

## Interface
Parameters:
- XLEN, 32, data/PC width
- MSTATUS_RST, 32'h0000_1800, mstatus reset value (MPP=M)

Ports:
- I_clk  in  1  clock; all state changes on rising edge
- I_rst  in  1  reset, synchronous, active-high
- I_valid  in  1  trap request valid from commit
- O_ready  out  1  controller can accept a request
- I_except  in  `Except_Bus (3)  one-hot-ish vector: `EXCPT_ECALL, `EXCPT_EBREAK, `EXCPT_MRET
- I_pc  in  XLEN  PC of the trapping instruction
- I_a0  in  XLEN  current x10 value, latched as halt code
- I_csr_we  in  1  CSR write enable (EX stage)
- I_csr_waddr  in  12  CSR write address
- I_csr_wdata  in  XLEN  CSR write data
- I_csr_raddr  in  12  CSR read address
- O_csr_rdata  out  XLEN  combinational CSR read data
- O_flush  out  1  one-cycle pipeline flush
- O_redirect_pc  out  XLEN  next fetch PC, valid while O_flush=1
- O_halt  out  1  simulation halt (macro-dependent)
- O_halt_code  out  XLEN  latched a0 at halt

## Operation
- CSRs: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342. Reset values: MSTATUS_RST, 0, 0, 0.
- Read of any other address returns 0. Writes to other addresses are dropped. mepc[1:0] is forced to 0 on every write.
- Priority when multiple bits are set: ECALL > EBREAK > MRET.
- A request with an all-zero I_except is ignored, and the FSM stays in IDLE.
- FSM states: IDLE, UPDATE, REDIRECT, HALT.
- IDLE:
  - O_ready=1.
  - On I_valid&&O_ready with a nonzero vector, latch the kind, I_pc and I_a0, then go to UPDATE.
  - If the macro is enabled and the request is EBREAK, go to HALT instead.
- UPDATE, trap (ECALL or non-halting EBREAK):
  - mepc<=pc.
  - mcause<=11 for ECALL, 3 for EBREAK.
  - MPIE<=MIE, MIE<=0, MPP<=2'b11.
- UPDATE, MRET:
  - MIE<=MPIE, MPIE<=1, MPP<=2'b11.
- UPDATE always goes to REDIRECT.
- REDIRECT:
  - O_flush=1.
  - O_redirect_pc = {mtvec[XLEN-1:2],2'b00} for a trap, or mepc for MRET, using the values as updated in UPDATE.
  - Go to IDLE.
- HALT: O_halt=1 and O_halt_code=latched a0. Absorbing state: O_ready=0 until I_rst.
- CSR port is active in every state.
  - When a trap update and an EX write target the same CSR in the same cycle, the trap update wins.
  - For different CSRs, both writes take effect.

## Timing
- Accept in cycle N, CSR update at the end of N+1, O_flush high in N+2 only, O_ready high again in N+3.
- Reset values: O_ready=1, O_flush=0, O_redirect_pc=0, O_halt=0, O_halt_code=0, O_csr_rdata = f(I_csr_raddr) with reset CSRs.
- O_redirect_pc is 0 whenever O_flush=0.
- O_csr_rdata is combinational. A read of an address being written in the same cycle returns the old value.
- I_rst asserted in any state: next cycle IDLE, all CSRs at reset values, flush/halt deasserted. A latched request is discarded.
- I_valid while O_ready=0 is neither accepted nor queued. Commit must hold it.

## Configuration
- TRAP_EBREAK_HALT_EN defined: EBREAK enters HALT. No CSR update and no flush occur. O_halt is asserted from cycle N+1.
- TRAP_EBREAK_HALT_EN undefined: EBREAK is a breakpoint exception with mcause=3, following the trap path. O_halt is tied to 0 and O_halt_code is tied to 0.

## Structure
- Shared defines.v holds:
  - CSR addresses (`CSR_MSTATUS`, `CSR_MTVEC`, `CSR_MEPC`, `CSR_MCAUSE`).
  - mcause codes (`MCAUSE_ECALL_M`=11, `MCAUSE_BREAKPOINT`=3).
  - FSM state encodings.
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
- Sub-module csr_file holds the four registers, the read mux, and the write-priority merge.
- trap_ctrl holds the FSM, the request latches and the redirect mux.

## Test plan
- Reset, then read 0x300/0x305/0x341/0x342 → 0x1800, 0, 0, 0. O_ready=1, O_flush=0.
- Write mtvec=0x8000_0103 and mstatus MIE=1, then issue ECALL at pc=0x8000_0040.
  - After UPDATE: mepc=0x8000_0040, mcause=11, MIE=0, MPIE=1.
  - N+2: O_flush=1, O_redirect_pc=0x8000_0100.
- Follow with MRET → MIE=1, MPIE=1. Redirect to 0x8000_0040, flush exactly one cycle.
- I_except=3'b011 (ECALL+EBREAK) with macro off → mcause=11. I_except=0 with I_valid=1 → no state change.
- Macro on, EBREAK with a0=0 → O_halt=1 and O_halt_code=0 from N+1, O_ready stays 0 until I_rst.
- Assert I_rst during REDIRECT → next cycle O_flush=0, IDLE, mepc=0. Same-cycle EX write to mepc during UPDATE → trap value retained.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared constants, state encodings and request decode for the
//               machine-mode trap controller.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    localparam logic [11:0] c_csr_mstatus = 12'h300;
    localparam logic [11:0] c_csr_mtvec   = 12'h305;
    localparam logic [11:0] c_csr_mepc    = 12'h341;
    localparam logic [11:0] c_csr_mcause  = 12'h342;

    localparam int c_mcause_ecall_m   = 11;
    localparam int c_mcause_breakpoint = 3;

    localparam int c_except_w    = 3;
    localparam int c_excpt_ecall  = 0;
    localparam int c_excpt_ebreak = 1;
    localparam int c_excpt_mret   = 2;

    localparam int c_mstatus_mie    = 3;
    localparam int c_mstatus_mpie   = 7;
    localparam int c_mstatus_mpp_lo = 11;
    localparam int c_mstatus_mpp_hi = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UPDATE   = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_ECALL  = 2'd0,
        KIND_EBREAK = 2'd1,
        KIND_MRET   = 2'd2
    } kind_t;

    // Fixed priority ECALL > EBREAK > MRET; caller guarantees a nonzero vector.
    function automatic kind_t decode_kind(input logic [c_except_w-1:0] except_vec);
        if (except_vec[c_excpt_ecall]) begin
            return KIND_ECALL;
        end else if (except_vec[c_excpt_ebreak]) begin
            return KIND_EBREAK;
        end else begin
            return KIND_MRET;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_csr_file.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_csr_file
// Description : mstatus/mtvec/mepc/mcause registers, combinational read mux and
//               merge of EX-stage writes with trap/MRET updates.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl_csr_file
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_trap_we,
    input  logic            i_mret_we,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic            i_ex_we,
    input  logic [11:0]     i_ex_waddr,
    input  logic [XLEN-1:0] i_ex_wdata,
    input  logic [11:0]     i_raddr,
    output logic [XLEN-1:0] o_rdata,
    output logic [XLEN-1:0] o_mtvec_base,
    output logic [XLEN-1:0] o_mepc
);

    localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] r_mstatus, r_mtvec, r_mepc, r_mcause;
    logic [XLEN-1:0] w_mstatus_d, w_mtvec_d, w_mepc_d, w_mcause_d;

    // EX write first; a trap/MRET update then overrides any register it owns.
    always_comb begin
        w_mstatus_d = r_mstatus;
        w_mtvec_d   = r_mtvec;
        w_mepc_d    = r_mepc;
        w_mcause_d  = r_mcause;
        if (i_ex_we) begin
            case (i_ex_waddr)
                c_csr_mstatus: w_mstatus_d = i_ex_wdata;
                c_csr_mtvec:   w_mtvec_d   = i_ex_wdata;
                c_csr_mepc:    w_mepc_d    = i_ex_wdata & c_align_mask;
                c_csr_mcause:  w_mcause_d  = i_ex_wdata;
                default: ;
            endcase
        end
        if (i_trap_we) begin
            w_mepc_d    = i_trap_pc & c_align_mask;
            w_mcause_d  = i_trap_cause;
            w_mstatus_d = r_mstatus;
            w_mstatus_d[c_mstatus_mpie] = r_mstatus[c_mstatus_mie];
            w_mstatus_d[c_mstatus_mie]  = 1'b0;
            w_mstatus_d[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = 2'b11;
        end else if (i_mret_we) begin
            w_mstatus_d = r_mstatus;
            w_mstatus_d[c_mstatus_mie]  = r_mstatus[c_mstatus_mpie];
            w_mstatus_d[c_mstatus_mpie] = 1'b1;
            w_mstatus_d[c_mstatus_mpp_hi:c_mstatus_mpp_lo] = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus <= MSTATUS_RST;
            r_mtvec   <= '0;
            r_mepc    <= '0;
            r_mcause  <= '0;
        end else begin
            r_mstatus <= w_mstatus_d;
            r_mtvec   <= w_mtvec_d;
            r_mepc    <= w_mepc_d;
            r_mcause  <= w_mcause_d;
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_raddr)
            c_csr_mstatus: o_rdata = r_mstatus;
            c_csr_mtvec:   o_rdata = r_mtvec;
            c_csr_mepc:    o_rdata = r_mepc;
            c_csr_mcause:  o_rdata = r_mcause;
            default:       o_rdata = '0;
        endcase
    end

    assign o_mtvec_base = r_mtvec & c_align_mask;
    assign o_mepc       = r_mepc;

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : M-mode trap controller: accepts ECALL/EBREAK/MRET from commit,
//               updates trap CSRs and issues a one-cycle flush with redirect PC.
//               Option macro TRAP_EBREAK_HALT_EN turns EBREAK into a halt.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_valid,
    output logic                  O_ready,
    input  logic [c_except_w-1:0] I_except,
    input  logic [XLEN-1:0]       I_pc,
    input  logic [XLEN-1:0]       I_a0,
    input  logic                  I_csr_we,
    input  logic [11:0]           I_csr_waddr,
    input  logic [XLEN-1:0]       I_csr_wdata,
    input  logic [11:0]           I_csr_raddr,
    output logic [XLEN-1:0]       O_csr_rdata,
    output logic                  O_flush,
    output logic [XLEN-1:0]       O_redirect_pc,
    output logic                  O_halt,
    output logic [XLEN-1:0]       O_halt_code
);

    state_t          r_state;
    kind_t           r_kind;
    logic [XLEN-1:0] r_pc;

    logic            w_accept;
    kind_t           w_req_kind;
    logic            w_trap_we;
    logic            w_mret_we;
    logic [XLEN-1:0] w_trap_cause;
    logic [XLEN-1:0] w_mtvec_base;
    logic [XLEN-1:0] w_mepc;

    assign O_ready    = (r_state == ST_IDLE);
    assign w_accept   = O_ready && I_valid && (I_except != '0);
    assign w_req_kind = decode_kind(I_except);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= ST_IDLE;
            r_kind  <= KIND_ECALL;
            r_pc    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_kind  <= w_req_kind;
                        r_pc    <= I_pc;
`ifdef TRAP_EBREAK_HALT_EN
                        r_state <= (w_req_kind == KIND_EBREAK) ? ST_HALT : ST_UPDATE;
`else
                        r_state <= ST_UPDATE;
`endif
                    end
                end
                ST_UPDATE:   r_state <= ST_REDIRECT;
                ST_REDIRECT: r_state <= ST_IDLE;
                ST_HALT:     r_state <= ST_HALT;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_trap_we    = (r_state == ST_UPDATE) && (r_kind != KIND_MRET);
    assign w_mret_we    = (r_state == ST_UPDATE) && (r_kind == KIND_MRET);
    assign w_trap_cause = (r_kind == KIND_ECALL) ? XLEN'(c_mcause_ecall_m)
                                                 : XLEN'(c_mcause_breakpoint);

    trap_ctrl_csr_file #(
        .XLEN        (XLEN),
        .MSTATUS_RST (MSTATUS_RST)
    ) u_csr_file (
        .clk          (I_clk),
        .rst          (I_rst),
        .i_trap_we    (w_trap_we),
        .i_mret_we    (w_mret_we),
        .i_trap_pc    (r_pc),
        .i_trap_cause (w_trap_cause),
        .i_ex_we      (I_csr_we),
        .i_ex_waddr   (I_csr_waddr),
        .i_ex_wdata   (I_csr_wdata),
        .i_raddr      (I_csr_raddr),
        .o_rdata      (O_csr_rdata),
        .o_mtvec_base (w_mtvec_base),
        .o_mepc       (w_mepc)
    );

    // Registers already hold the UPDATE-cycle results by the time REDIRECT runs.
    assign O_flush       = (r_state == ST_REDIRECT);
    assign O_redirect_pc = !O_flush               ? '0
                         : (r_kind == KIND_MRET)  ? w_mepc
                         :                          w_mtvec_base;

`ifdef TRAP_EBREAK_HALT_EN
    logic            r_halt;
    logic [XLEN-1:0] r_halt_code;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_halt      <= 1'b0;
            r_halt_code <= '0;
        end else if (w_accept && (w_req_kind == KIND_EBREAK)) begin
            r_halt      <= 1'b1;
            r_halt_code <= I_a0;
        end
    end

    assign O_halt      = r_halt;
    assign O_halt_code = r_halt_code;
`else
    logic w_unused_a0;
    assign w_unused_a0 = ^I_a0;
    assign O_halt      = 1'b0;
    assign O_halt_code = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Directed self-checking bench for trap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_trap_ctrl;

    logic        I_clk = 1'b0;
    logic        I_rst;
    logic        I_valid;
    logic        O_ready;
    logic [2:0]  I_except;
    logic [31:0] I_pc;
    logic [31:0] I_a0;
    logic        I_csr_we;
    logic [11:0] I_csr_waddr;
    logic [31:0] I_csr_wdata;
    logic [11:0] I_csr_raddr;
    logic [31:0] O_csr_rdata;
    logic        O_flush;
    logic [31:0] O_redirect_pc;
    logic        O_halt;
    logic [31:0] O_halt_code;

    int n_cmp = 0;
    int n_err = 0;

    trap_ctrl #(
        .XLEN        (32),
        .MSTATUS_RST (32'h0000_1800)
    ) dut (
        .I_clk         (I_clk),
        .I_rst         (I_rst),
        .I_valid       (I_valid),
        .O_ready       (O_ready),
        .I_except      (I_except),
        .I_pc          (I_pc),
        .I_a0          (I_a0),
        .I_csr_we      (I_csr_we),
        .I_csr_waddr   (I_csr_waddr),
        .I_csr_wdata   (I_csr_wdata),
        .I_csr_raddr   (I_csr_raddr),
        .O_csr_rdata   (O_csr_rdata),
        .O_flush       (O_flush),
        .O_redirect_pc (O_redirect_pc),
        .O_halt        (O_halt),
        .O_halt_code   (O_halt_code)
    );

    always #10 I_clk = ~I_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        I_csr_raddr = addr;
        #1;
        check(tag, O_csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        I_csr_we    = 1'b1;
        I_csr_waddr = addr;
        I_csr_wdata = data;
        tick();
        I_csr_we    = 1'b0;
    endtask

    initial begin
        I_rst = 1'b1; I_valid = 1'b0; I_except = '0; I_pc = '0; I_a0 = '0;
        I_csr_we = 1'b0; I_csr_waddr = '0; I_csr_wdata = '0; I_csr_raddr = '0;
        tick(); tick();
        I_rst = 1'b0;
        tick();

        // Reset state
        check("rst_ready", {31'd0, O_ready}, 32'd1);
        check("rst_flush", {31'd0, O_flush}, 32'd0);
        check("rst_redir", O_redirect_pc, 32'd0);
        check("rst_halt", {31'd0, O_halt}, 32'd0);
        check("rst_hcode", O_halt_code, 32'd0);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mtvec", 12'h305, 32'd0);
        rd("rst_mepc", 12'h341, 32'd0);
        rd("rst_mcause", 12'h342, 32'd0);

        // CSR port: mepc alignment, dropped writes, setup for ECALL
        wr(12'h341, 32'h1234_5677);
        rd("mepc_align", 12'h341, 32'h1234_5674);
        wr(12'h123, 32'hFFFF_FFFF);
        rd("unmapped_rd", 12'h123, 32'd0);
        wr(12'h305, 32'h8000_0103);
        wr(12'h300, 32'h0000_1808);
        rd("mtvec_wr", 12'h305, 32'h8000_0103);
        rd("mstatus_wr", 12'h300, 32'h0000_1808);

        // ECALL at 0x8000_0040
        I_valid = 1'b1; I_except = 3'b001; I_pc = 32'h8000_0040; I_a0 = 32'h0;
        tick();
        I_valid = 1'b0; I_except = '0;
        check("ecall_n1_ready", {31'd0, O_ready}, 32'd0);
        check("ecall_n1_flush", {31'd0, O_flush}, 32'd0);
        tick();
        check("ecall_flush", {31'd0, O_flush}, 32'd1);
        check("ecall_redir", O_redirect_pc, 32'h8000_0100);
        rd("ecall_mepc", 12'h341, 32'h8000_0040);
        rd("ecall_mcause", 12'h342, 32'd11);
        rd("ecall_mstatus", 12'h300, 32'h0000_1880);
        tick();
        check("ecall_n3_flush", {31'd0, O_flush}, 32'd0);
        check("ecall_n3_redir", O_redirect_pc, 32'd0);
        check("ecall_n3_ready", {31'd0, O_ready}, 32'd1);

        // MRET back to mepc
        I_valid = 1'b1; I_except = 3'b100; I_pc = 32'h8000_0100;
        tick();
        I_valid = 1'b0; I_except = '0;
        tick();
        check("mret_flush", {31'd0, O_flush}, 32'd1);
        check("mret_redir", O_redirect_pc, 32'h8000_0040);
        rd("mret_mstatus", 12'h300, 32'h0000_1888);
        tick();
        check("mret_flush_off", {31'd0, O_flush}, 32'd0);

        // ECALL+EBREAK together: ECALL wins
        I_valid = 1'b1; I_except = 3'b011; I_pc = 32'h8000_0200;
        tick();
        I_valid = 1'b0; I_except = '0;
        tick();
        check("prio_redir", O_redirect_pc, 32'h8000_0100);
        rd("prio_mcause", 12'h342, 32'd11);
        rd("prio_mepc", 12'h341, 32'h8000_0200);
        rd("prio_mstatus", 12'h300, 32'h0000_1880);
        tick();

`ifndef TRAP_EBREAK_HALT_EN
        // EBREAK as breakpoint exception
        I_valid = 1'b1; I_except = 3'b010; I_pc = 32'h8000_0300;
        tick();
        I_valid = 1'b0; I_except = '0;
        tick();
        check("ebrk_flush", {31'd0, O_flush}, 32'd1);
        check("ebrk_redir", O_redirect_pc, 32'h8000_0100);
        rd("ebrk_mcause", 12'h342, 32'd3);
        rd("ebrk_mepc", 12'h341, 32'h8000_0300);
        rd("ebrk_mstatus", 12'h300, 32'h0000_1800);
        tick();
        check("ebrk_halt", {31'd0, O_halt}, 32'd0);
`endif

        // Zero vector with valid is ignored
        I_valid = 1'b1; I_except = 3'b000; I_pc = 32'h8000_0500;
        tick();
        check("zero_ready", {31'd0, O_ready}, 32'd1);
        tick();
        I_valid = 1'b0;
        check("zero_flush", {31'd0, O_flush}, 32'd0);
        rd("zero_mepc", 12'h341, 32'h8000_0200 + ((`ifndef TRAP_EBREAK_HALT_EN 1 `else 0 `endif) * 32'h100));

        // EX write to mepc during UPDATE loses to the trap; reset during REDIRECT
        I_valid = 1'b1; I_except = 3'b001; I_pc = 32'h8000_0400;
        tick();
        I_valid = 1'b0; I_except = '0;
        I_csr_we = 1'b1; I_csr_waddr = 12'h341; I_csr_wdata = 32'hDEAD_BEEC;
        rd("same_cyc_old", 12'h341, 32'h8000_0200 + ((`ifndef TRAP_EBREAK_HALT_EN 1 `else 0 `endif) * 32'h100));
        tick();
        I_csr_we = 1'b0;
        rd("conflict_mepc", 12'h341, 32'h8000_0400);
        check("conflict_flush", {31'd0, O_flush}, 32'd1);
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        check("rstredir_flush", {31'd0, O_flush}, 32'd0);
        check("rstredir_redir", O_redirect_pc, 32'd0);
        check("rstredir_ready", {31'd0, O_ready}, 32'd1);
        rd("rstredir_mepc", 12'h341, 32'd0);
        rd("rstredir_mtvec", 12'h305, 32'd0);
        rd("rstredir_mstatus", 12'h300, 32'h0000_1800);

        // EX write to mtvec during UPDATE coexists with the trap update
        I_valid = 1'b1; I_except = 3'b001; I_pc = 32'h0000_0040;
        tick();
        I_valid = 1'b0; I_except = '0;
        I_csr_we = 1'b1; I_csr_waddr = 12'h305; I_csr_wdata = 32'h0000_1007;
        tick();
        I_csr_we = 1'b0;
        check("dual_redir", O_redirect_pc, 32'h0000_1004);
        rd("dual_mtvec", 12'h305, 32'h0000_1007);
        rd("dual_mepc", 12'h341, 32'h0000_0040);
        rd("dual_mcause", 12'h342, 32'd11);
        tick();

`ifdef TRAP_EBREAK_HALT_EN
        // EBREAK halts: no CSR update, no flush, absorbing until reset
        I_valid = 1'b1; I_except = 3'b010; I_pc = 32'h0000_0080; I_a0 = 32'h0000_0005;
        tick();
        I_valid = 1'b0; I_except = '0;
        check("halt_n1", {31'd0, O_halt}, 32'd1);
        check("halt_code", O_halt_code, 32'h0000_0005);
        check("halt_ready", {31'd0, O_ready}, 32'd0);
        I_valid = 1'b1; I_except = 3'b001;
        tick(); tick(); tick();
        I_valid = 1'b0; I_except = '0;
        check("halt_hold_ready", {31'd0, O_ready}, 32'd0);
        check("halt_hold_flush", {31'd0, O_flush}, 32'd0);
        rd("halt_mepc", 12'h341, 32'h0000_0040);
        I_rst = 1'b1;
        tick();
        I_rst = 1'b0;
        check("halt_rst", {31'd0, O_halt}, 32'd0);
        check("halt_rst_code", O_halt_code, 32'd0);
        check("halt_rst_ready", {31'd0, O_ready}, 32'd1);
`else
        I_valid = 1'b1; I_except = 3'b010; I_pc = 32'h0000_0080; I_a0 = 32'h0000_0005;
        tick();
        I_valid = 1'b0; I_except = '0;
        check("nohalt_halt", {31'd0, O_halt}, 32'd0);
        check("nohalt_code", O_halt_code, 32'd0);
        tick(); tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
